// File: rtl/rat_io_bridge.sv
// I/O bridge between the RAT MCU port bus and the board: LED and display
// write registers, a switch/status read mux, and a debounced button interrupt.
module rat_io_bridge #(
    parameter logic [15:0] DB_COUNT  = 16'd50000,
    parameter logic [7:0]  LED_ID    = 8'h40,
    parameter logic [7:0]  SSEG_ID   = 8'h81,
    parameter logic [7:0]  SW_ID     = 8'h20,
    parameter logic [7:0]  STAT_ID   = 8'h21,
    parameter logic [7:0]  INTCLR_ID = 8'hF0
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    input  logic [7:0] SWITCHES,
    input  logic       BTN,
    output logic [7:0] IN_PORT,
    output logic [7:0] LEDS,
    output logic [7:0] SSEG_VAL,
    output logic       INT_CU
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        PRESSED = 2'd2,
        WAIT_LO = 2'd3
    } db_state_t;

    localparam logic [15:0] DB_LAST = DB_COUNT - 16'd1;

    logic [1:0]  sync_pipe;
    logic        btn_s;
    db_state_t   state, state_next;
    logic [15:0] cnt, cnt_next;
    logic        press;
    logic        int_clr;

    assign btn_s   = sync_pipe[1];
    assign int_clr = IO_STRB && (PORT_ID == INTCLR_ID);

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) sync_pipe <= 2'b00;
        else          sync_pipe <= {sync_pipe[0], BTN};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Level must hold DB_COUNT cycles past the state entry to qualify.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        press      = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next = WAIT_HI;
                    cnt_next   = 16'd0;
                end
            end
            WAIT_HI: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    cnt_next   = 16'd0;
                end else if (cnt == DB_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = 16'd0;
                    press      = 1'b1;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_next = WAIT_LO;
                    cnt_next   = 16'd0;
                end
            end
            WAIT_LO: begin
                if (btn_s) begin
                    state_next = PRESSED;
                    cnt_next   = 16'd0;
                end else if (cnt == DB_LAST) begin
                    state_next = IDLE;
                    cnt_next   = 16'd0;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 16'd0;
            end
        endcase
    end

    // A press on the same edge as a clear keeps the interrupt pending.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)     INT_CU <= 1'b0;
        else if (press)   INT_CU <= 1'b1;
        else if (int_clr) INT_CU <= 1'b0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            LEDS     <= 8'h00;
            SSEG_VAL <= 8'h00;
        end else if (IO_STRB) begin
            if (PORT_ID == LED_ID)  LEDS     <= OUT_PORT;
            if (PORT_ID == SSEG_ID) SSEG_VAL <= OUT_PORT;
        end
    end

    always_comb begin
        IN_PORT = 8'h00;
        if (PORT_ID == SW_ID)        IN_PORT = SWITCHES;
        else if (PORT_ID == STAT_ID) IN_PORT = {7'b0, INT_CU};
    end

endmodule

// File: tb/tb_rat_io_bridge.sv
// Bench for rat_io_bridge with DB_COUNT=4: directed scenarios plus a random
// run checked against a run-length model of the debounced button.
module tb_rat_io_bridge;

    localparam int DBC = 4;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b1;
    logic [7:0] PORT_ID = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic       IO_STRB = 1'b0;
    logic [7:0] SWITCHES = 8'h00;
    logic       BTN = 1'b0;
    logic [7:0] IN_PORT;
    logic [7:0] LEDS;
    logic [7:0] SSEG_VAL;
    logic       INT_CU;

    int total = 0;
    int bad = 0;

    rat_io_bridge #(.DB_COUNT(16'd4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
        .IO_STRB(IO_STRB), .SWITCHES(SWITCHES), .BTN(BTN), .IN_PORT(IN_PORT),
        .LEDS(LEDS), .SSEG_VAL(SSEG_VAL), .INT_CU(INT_CU)
    );

    always #5 CLK = ~CLK;

    // Model: btn_s is BTN two samples late; the debounced level flips once
    // the opposite level has been seen for DBC+1 consecutive samples.
    logic [7:0] m_leds, m_sseg;
    logic       m_pend, m_b1, m_b2, m_stable;
    int         m_run, m_presses;

    task automatic model_reset();
        m_leds = 8'h00; m_sseg = 8'h00; m_pend = 1'b0;
        m_b1 = 1'b0; m_b2 = 1'b0; m_stable = 1'b0; m_run = 0;
    endtask

    task automatic model_edge();
        logic bs, pr;
        if (!RESET_N) begin
            model_reset();
            return;
        end
        bs = m_b2; m_b2 = m_b1; m_b1 = BTN;
        pr = 1'b0;
        if (bs != m_stable) begin
            m_run++;
            if (m_run == DBC + 1) begin
                m_stable = bs;
                m_run = 0;
                pr = bs;
            end
        end else begin
            m_run = 0;
        end
        if (IO_STRB && PORT_ID == 8'h40) m_leds = OUT_PORT;
        if (IO_STRB && PORT_ID == 8'h81) m_sseg = OUT_PORT;
        if (pr) begin
            m_pend = 1'b1;
            m_presses++;
        end else if (IO_STRB && PORT_ID == 8'hF0) begin
            m_pend = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        model_reset();
        BTN = 1'b0; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        #2 RESET_N = 1'b0;
        model_reset();
        #1;
        total++;
        if (LEDS !== 8'h00 || SSEG_VAL !== 8'h00 || INT_CU !== 1'b0) begin
            bad++;
            $display("FAIL reset_async leds=%h sseg=%h int=%b exp 00/00/0", LEDS, SSEG_VAL, INT_CU);
        end
        tick();
        RESET_N = 1'b1;
    endtask

    task automatic test_write_decode();
        do_reset();
        IO_STRB = 1'b1; PORT_ID = 8'h40; OUT_PORT = 8'hA5;
        tick();
        IO_STRB = 1'b0;
        total++;
        if (LEDS !== 8'hA5 || SSEG_VAL !== 8'h00) begin
            bad++;
            $display("FAIL wr_led leds=%h sseg=%h exp a5/00", LEDS, SSEG_VAL);
        end
        IO_STRB = 1'b1; PORT_ID = 8'h41; OUT_PORT = 8'h5A;
        tick();
        IO_STRB = 1'b0;
        total++;
        if (LEDS !== 8'hA5 || SSEG_VAL !== 8'h00) begin
            bad++;
            $display("FAIL wr_other leds=%h sseg=%h exp a5/00", LEDS, SSEG_VAL);
        end
        PORT_ID = 8'h40; OUT_PORT = 8'h11;
        tick();
        total++;
        if (LEDS !== 8'hA5) begin
            bad++;
            $display("FAIL wr_nostrb leds=%h exp a5", LEDS);
        end
        IO_STRB = 1'b1; PORT_ID = 8'h81; OUT_PORT = 8'h3E;
        tick();
        IO_STRB = 1'b0;
        total++;
        if (SSEG_VAL !== 8'h3E || LEDS !== 8'hA5) begin
            bad++;
            $display("FAIL wr_sseg sseg=%h leds=%h exp 3e/a5", SSEG_VAL, LEDS);
        end
    endtask

    task automatic test_read_mux();
        SWITCHES = 8'h3C; PORT_ID = 8'h20; IO_STRB = 1'b0;
        #1;
        total++;
        if (IN_PORT !== 8'h3C) begin
            bad++;
            $display("FAIL rd_sw in=%h exp 3c", IN_PORT);
        end
        PORT_ID = 8'h55;
        #1;
        total++;
        if (IN_PORT !== 8'h00) begin
            bad++;
            $display("FAIL rd_other in=%h exp 00", IN_PORT);
        end
        PORT_ID = 8'h21;
        #1;
        total++;
        if (IN_PORT !== 8'h00) begin
            bad++;
            $display("FAIL rd_stat_idle in=%h exp 00", IN_PORT);
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        BTN = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            total++;
            if (INT_CU !== (e == 7)) begin
                bad++;
                $display("FAIL press_latency edge=%0d int=%b exp %b", e, INT_CU, e == 7);
            end
        end
        PORT_ID = 8'h21;
        #1;
        total++;
        if (IN_PORT !== 8'h01) begin
            bad++;
            $display("FAIL rd_stat in=%h exp 01", IN_PORT);
        end
        IO_STRB = 1'b1; PORT_ID = 8'hF0;
        tick();
        IO_STRB = 1'b0;
        total++;
        if (INT_CU !== 1'b0) begin
            bad++;
            $display("FAIL int_clear int=%b exp 0", INT_CU);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            total++;
            if (INT_CU !== 1'b0) begin
                bad++;
                $display("FAIL held_no_reassert cyc=%0d int=%b exp 0", i, INT_CU);
            end
        end
    endtask

    task automatic test_bounce();
        int rises;
        logic prev;
        do_reset();
        rises = 0; prev = 1'b0;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 3; k++) begin
                BTN = (k != 2);
                tick();
                if (INT_CU && !prev) rises++;
                prev = INT_CU;
            end
        end
        BTN = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (INT_CU && !prev) begin
                rises++;
                total++;
                if (e != 7) begin
                    bad++;
                    $display("FAIL bounce_edge edge=%0d exp 7", e);
                end
            end
            prev = INT_CU;
        end
        total++;
        if (rises != 1) begin
            bad++;
            $display("FAIL bounce_count rises=%0d exp 1", rises);
        end
    endtask

    task automatic test_collision();
        do_reset();
        BTN = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            if (e == 7) begin
                IO_STRB = 1'b1; PORT_ID = 8'hF0;
            end
            tick();
        end
        IO_STRB = 1'b0;
        total++;
        if (INT_CU !== 1'b1) begin
            bad++;
            $display("FAIL set_clr_collide int=%b exp 1", INT_CU);
        end
        tick();
        total++;
        if (INT_CU !== 1'b1) begin
            bad++;
            $display("FAIL collide_hold int=%b exp 1", INT_CU);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        IO_STRB = 1'b1; PORT_ID = 8'h40; OUT_PORT = 8'hFF;
        BTN = 1'b1;
        tick();
        IO_STRB = 1'b0;
        for (int e = 2; e <= 7; e++) tick();
        BTN = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        BTN = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (INT_CU !== 1'b1 || LEDS !== 8'hFF) begin
            bad++;
            $display("FAIL pre_reset int=%b leds=%h exp 1/ff", INT_CU, LEDS);
        end
        #2 RESET_N = 1'b0;
        model_reset();
        #1;
        total++;
        if (LEDS !== 8'h00 || INT_CU !== 1'b0) begin
            bad++;
            $display("FAIL async_reset leds=%h int=%b exp 00/0", LEDS, INT_CU);
        end
        IO_STRB = 1'b1; PORT_ID = 8'h40; OUT_PORT = 8'h77;
        tick();
        tick();
        IO_STRB = 1'b0;
        total++;
        if (LEDS !== 8'h00) begin
            bad++;
            $display("FAIL strobe_in_reset leds=%h exp 00", LEDS);
        end
        RESET_N = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            total++;
            if (INT_CU !== (e == 7)) begin
                bad++;
                $display("FAIL post_reset_qual edge=%0d int=%b exp %b", e, INT_CU, e == 7);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] ids [5];
        logic [7:0] exp_in;
        ids[0] = 8'h40; ids[1] = 8'h81; ids[2] = 8'hF0; ids[3] = 8'h20; ids[4] = 8'h21;
        do_reset();
        m_presses = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) BTN = ~BTN;
            IO_STRB  = ($urandom_range(0, 5) == 0);
            PORT_ID  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : ids[$urandom_range(0, 4)];
            OUT_PORT = 8'($urandom);
            SWITCHES = 8'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                RESET_N = 1'b0;
                model_reset();
            end else begin
                RESET_N = 1'b1;
            end
            #1;
            exp_in = (PORT_ID == 8'h20) ? SWITCHES :
                     (PORT_ID == 8'h21) ? {7'b0, m_pend} : 8'h00;
            total++;
            if (IN_PORT !== exp_in) begin
                bad++;
                $display("FAIL rnd_in cyc=%0d in=%h exp %h", i, IN_PORT, exp_in);
            end
            tick();
            total++;
            if (LEDS !== m_leds || SSEG_VAL !== m_sseg || INT_CU !== m_pend) begin
                bad++;
                $display("FAIL rnd_out cyc=%0d leds=%h sseg=%h int=%b exp %h/%h/%b",
                         i, LEDS, SSEG_VAL, INT_CU, m_leds, m_sseg, m_pend);
            end
        end
        RESET_N = 1'b1;
        IO_STRB = 1'b0;
        total++;
        if (m_presses < 10) begin
            bad++;
            $display("FAIL rnd_coverage presses=%0d exp >=10", m_presses);
        end
    endtask

    initial begin
        m_presses = 0;
        model_reset();
        test_reset();
        test_write_decode();
        test_read_mux();
        test_clean_press();
        test_bounce();
        test_collision();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
